// File: rtl/tx_sample_feeder.sv
// tx_sample_feeder -- transmit baseband sample FIFO between the host I/O port
// and the AGC/clipper sample request.
//
// The host writes X to port 0, then Y to port 1. Writing port 1 pushes the
// {X, Y} pair. Writing port 2 with bit0 set flushes the FIFO. Each one-cycle
// tie request yields one tdox/tdoy sample with a tov pulse on the next cycle.
// An empty FIFO on tie gives an underflow sample and sets the sticky UNF flag.
// A push into a full FIFO is dropped and sets the sticky OVF flag.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   xmt            T/R switch (1 = transmit); while 0 the FIFO is held empty
//   iocs/ioaddr/iowr/din   host write port
//   iord, dout     host status read: {UNF, OVF, 6'b0, level[7:0]};
//                  iord with ioaddr=2 also clears UNF/OVF
//   tie            sample request
//   tdox, tdoy, tov  sample output and its valid pulse
//
// Build option: TXFEED_HOLD_EN -- an underflow repeats the last delivered
// pair instead of 0/0.
module tx_sample_feeder #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xmt,
  input  logic        iocs,
  input  logic [2:0]  ioaddr,
  input  logic        iowr,
  input  logic [15:0] din,
  input  logic        iord,
  output logic [15:0] dout,
  input  logic        tie,
  output logic [15:0] tdox,
  output logic [15:0] tdoy,
  output logic        tov
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pair_t;

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [LW-1:0]  level;
  logic [15:0]    xhold;
  logic           unf, ovf;
  pair_t          last;

  logic  wr, ld_x, push_req, flush, empty, full;
  logic  pop, push, ovf_set, unf_set, clr;
  pair_t head, uflow;

  assign wr       = iocs & iowr;
  assign ld_x     = wr & (ioaddr == 3'd0);
  assign push_req = wr & (ioaddr == 3'd1);
  assign flush    = wr & (ioaddr == 3'd2) & din[0];
  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));

  // Emptiness is judged on the registered level, so a push landing in the
  // same cycle as tie never bypasses to the output.
  assign pop      = tie & xmt & ~empty;
  // A flush wins over a coincident push; at full a push rides on a pop.
  assign push     = push_req & xmt & ~flush & (~full | pop);
  assign ovf_set  = push_req & xmt & ~flush & full & ~pop;
  assign unf_set  = tie & xmt & empty;
  assign clr      = iord & (ioaddr == 3'd2);
  assign head     = mem[rptr];

`ifdef TXFEED_HOLD_EN
  assign uflow = xmt ? last : '0;
`else
  assign uflow = '0;
`endif

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= {xhold, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      xhold <= '0;
      unf   <= 1'b0;
      ovf   <= 1'b0;
      last  <= '0;
      tdox  <= '0;
      tdoy  <= '0;
      tov   <= 1'b0;
      dout  <= '0;
    end else begin
      if (ld_x) xhold <= din;

      if (!xmt || flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
        last  <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
        if (pop) last <= head;
      end

      tov <= tie;
      if (tie) begin
        if (pop) begin
          tdox <= head.x;
          tdoy <= head.y;
        end else begin
          tdox <= uflow.x;
          tdoy <= uflow.y;
        end
      end

      // Status captures pre-update flags/level; a set in the same cycle
      // overrides the read-clear.
      if (iord) dout <= {unf, ovf, 6'b0, 8'(level)};
      if (unf_set)  unf <= 1'b1;
      else if (clr) unf <= 1'b0;
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tx_sample_feeder.sv
// Directed bench for tx_sample_feeder (DEPTH=16). Inputs change 1 time unit
// after the rising edge; outputs are sampled there too.
module tb_tx_sample_feeder;
  logic        clk = 1'b0;
  logic        rst, xmt, iocs, iowr, iord, tie, tov;
  logic [2:0]  ioaddr;
  logic [15:0] din, dout, tdox, tdoy;
  int          vec = 0;
  int          errs = 0;

  tx_sample_feeder #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .xmt(xmt), .iocs(iocs), .ioaddr(ioaddr),
    .iowr(iowr), .din(din), .iord(iord), .dout(dout), .tie(tie),
    .tdox(tdox), .tdoy(tdoy), .tov(tov)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    iocs = 1'b1; iowr = 1'b1; ioaddr = a; din = d;
    tick();
    iocs = 1'b0; iowr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    iord = 1'b1; ioaddr = a;
    tick();
    iord = 1'b0;
  endtask

  task automatic pulse_tie();
    tie = 1'b1;
    tick();
    tie = 1'b0;
  endtask

  initial begin
    logic [15:0] hx, hy;
    rst = 1'b1; xmt = 1'b0; iocs = 1'b0; iowr = 1'b0; iord = 1'b0;
    tie = 1'b0; ioaddr = 3'd0; din = 16'h0;
    tick(); tick();
    chk("rst_dout", dout, 16'h0000);
    chk("rst_tov", {15'b0, tov}, 16'h0000);
    chk("rst_tdox", tdox, 16'h0000);
    chk("rst_tdoy", tdoy, 16'h0000);
    rst = 1'b0; xmt = 1'b1;
    tick();

    // Basic write/read of one pair
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'hABCD);
    rd(3'd0);
    chk("lvl1", dout, 16'h0001);
    pulse_tie();
    chk("basic_tov", {15'b0, tov}, 16'h0001);
    chk("basic_x", tdox, 16'h1234);
    chk("basic_y", tdoy, 16'hABCD);
    tick();
    chk("tov_once", {15'b0, tov}, 16'h0000);
    rd(3'd0);
    chk("lvl0", dout, 16'h0000);

    // Underflow on empty FIFO
`ifdef TXFEED_HOLD_EN
    hx = 16'h1234; hy = 16'hABCD;
`else
    hx = 16'h0000; hy = 16'h0000;
`endif
    pulse_tie();
    chk("unf_tov", {15'b0, tov}, 16'h0001);
    chk("unf_x", tdox, hx);
    chk("unf_y", tdoy, hy);
    rd(3'd2);
    chk("unf_stat", dout, 16'h8000);
    rd(3'd0);
    chk("unf_clr", dout, 16'h0000);

    // Hold/zero after a delivered 0x0100/0xFF00
    wr(3'd0, 16'h0100);
    wr(3'd1, 16'hFF00);
    pulse_tie();
    chk("hold_dx", tdox, 16'h0100);
    chk("hold_dy", tdoy, 16'hFF00);
`ifdef TXFEED_HOLD_EN
    hx = 16'h0100; hy = 16'hFF00;
`endif
    pulse_tie();
    chk("hold_ux", tdox, hx);
    chk("hold_uy", tdoy, hy);
    chk("hold_tov", {15'b0, tov}, 16'h0001);
    rd(3'd2);
    chk("hold_stat", dout, 16'h8000);

    // 17 pushes into DEPTH=16
    for (int i = 0; i < 17; i++) begin
      wr(3'd0, 16'(i));
      wr(3'd1, 16'(i + 16'h0100));
    end
    rd(3'd0);
    chk("ovf_stat", dout, 16'h4010);
    rd(3'd2);
    chk("ovf_stat2", dout, 16'h4010);
    rd(3'd0);
    chk("ovf_clr", dout, 16'h0010);

    // Full FIFO: push + tie in the same cycle
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'h5555; tie = 1'b1;
    tick();
    iocs = 1'b0; iowr = 1'b0; tie = 1'b0;
    chk("fullpp_x", tdox, 16'h0000);
    chk("fullpp_y", tdoy, 16'h0100);
    chk("fullpp_tov", {15'b0, tov}, 16'h0001);
    rd(3'd0);
    chk("fullpp_stat", dout, 16'h0010);

    // Drain with back-to-back ties
    tie = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) begin
        chk("drain_x", tdox, 16'(i + 1));
        chk("drain_y", tdoy, 16'(i + 16'h0101));
      end else begin
        chk("drain_lx", tdox, 16'h0010);
        chk("drain_ly", tdoy, 16'h5555);
      end
    end
    tie = 1'b0;
    rd(3'd0);
    chk("drain_stat", dout, 16'h0000);

    // Flush
    wr(3'd1, 16'h0001);
    wr(3'd1, 16'h0002);
    wr(3'd2, 16'h0001);
    rd(3'd0);
    chk("flush_lvl", dout, 16'h0000);

    // xmt=0 holds FIFO empty
    for (int i = 0; i < 5; i++) wr(3'd1, 16'(i));
    rd(3'd0);
    chk("q5", dout, 16'h0005);
    xmt = 1'b0;
    tick();
    rd(3'd0);
    chk("rx_lvl", dout, 16'h0000);
    pulse_tie();
    chk("rx_tov", {15'b0, tov}, 16'h0001);
    chk("rx_x", tdox, 16'h0000);
    chk("rx_y", tdoy, 16'h0000);
    wr(3'd1, 16'h7777);
    rd(3'd0);
    chk("rx_stat", dout, 16'h0000);
    xmt = 1'b1;

    // Reset the cycle after tie
    wr(3'd0, 16'h4444);
    wr(3'd1, 16'h3333);
    pulse_tie();
    chk("prer_tov", {15'b0, tov}, 16'h0001);
    rst = 1'b1; tie = 1'b1; iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; iord = 1'b1;
    tick();
    rst = 1'b0; tie = 1'b0; iocs = 1'b0; iowr = 1'b0; iord = 1'b0;
    chk("r_tov", {15'b0, tov}, 16'h0000);
    chk("r_x", tdox, 16'h0000);
    chk("r_y", tdoy, 16'h0000);
    chk("r_dout", dout, 16'h0000);
    rd(3'd0);
    chk("r_lvl", dout, 16'h0000);

    // Push + tie into empty: no bypass, underflow
    wr(3'd0, 16'h2222);
    iocs = 1'b1; iowr = 1'b1; ioaddr = 3'd1; din = 16'h1111; tie = 1'b1;
    tick();
    iocs = 1'b0; iowr = 1'b0; tie = 1'b0;
    chk("nb_x", tdox, 16'h0000);
    chk("nb_y", tdoy, 16'h0000);
    rd(3'd0);
    chk("nb_stat", dout, 16'h8001);
    pulse_tie();
    chk("nb_px", tdox, 16'h2222);
    chk("nb_py", tdoy, 16'h1111);

    // Clear coinciding with a new underflow: set wins
    iord = 1'b1; ioaddr = 3'd2; tie = 1'b1;
    tick();
    iord = 1'b0; tie = 1'b0;
    chk("sw_cap", dout, 16'h8000);
    rd(3'd0);
    chk("sw_keep", dout, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
